shift_rows_pipe: RTL and testbench

//  Parametrised Rijndael ShiftRows / InvShiftRows stage for block widths Nb = 4, 6 or 8 columns.
//  Per-transaction mode select (forward or inverse), with a valid/ready handshake and a 2-entry skid buffer.

---
 rtl/aes_pkg.sv | 14 +
 rtl/shift_rows_comb.sv | 23 ++
 rtl/shift_rows_pipe.sv | 82 ++++++++
 tb/tb_shift_rows_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared helpers for the Rijndael row-shift stage: row offsets and legal column counts.
package aes_pkg;

  // Rijndael row offsets: {0,1,2,3} for Nb = 4 or 6, and {0,1,3,4} for Nb = 8.
  function automatic int unsigned shift_off(int unsigned nb, int unsigned r);
    if (nb == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  function automatic bit nb_legal(int unsigned nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

endpackage

// File: rtl/shift_rows_comb.sv
// Combinational ShiftRows / InvShiftRows over a row-major Nb-column state.
module shift_rows_comb
  import aes_pkg::*;
#(
  parameter int unsigned NB = 4,
  localparam int unsigned W = 32 * NB
) (
  input  logic [W-1:0] in_data,
  input  logic         inv,
  output logic [W-1:0] out_data
);

  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam int unsigned Off = shift_off(NB, r);
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int unsigned FwdSrc = (c + Off) % NB;
      localparam int unsigned InvSrc = (c + NB - Off) % NB;
      assign out_data[W-1-8*(r*NB+c) -: 8] = inv ? in_data[W-1-8*(r*NB+InvSrc) -: 8]
                                                 : in_data[W-1-8*(r*NB+FwdSrc) -: 8];
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// ShiftRows pipeline stage: transform at accept, then a 2-entry in-order skid buffer
// with a registered in_ready so upstream timing never sees out_ready.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int unsigned NB    = 4,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned W    = 32 * NB
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_inv,
  input  logic [W-1:0]     in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam bit NbOk = nb_legal(NB);
  if (!NbOk) begin : g_nb_check
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  logic [W-1:0]     shifted;
  logic [W-1:0]     data_q [2];
  logic [TAG_W-1:0] tag_q  [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             ready_q;
  logic             push, pop;

  shift_rows_comb #(.NB(NB)) u_shift (
    .in_data  (in_data),
    .inv      (in_inv),
    .out_data (shifted)
  );

  assign push = in_valid && ready_q;
  assign pop  = (count_q != 2'd0) && out_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      tag_q[0]  <= '0;
      tag_q[1]  <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      ready_q   <= 1'b0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= shifted;
        tag_q[wr_ptr_q]  <= in_tag;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
      // Registered from next occupancy, so it never follows out_ready in the same cycle.
      ready_q <= (count_d < 2'd2);
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = data_q[rd_ptr_q];
  assign out_tag   = tag_q[rd_ptr_q];

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Self-checking bench for shift_rows_pipe: vector table, scoreboard, backpressure, reset.
module tb_shift_rows_pipe;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // NB = 4 instance (main)
  logic         in_valid, in_ready, in_inv, out_valid, out_ready;
  logic [127:0] in_data, out_data, exp_data;
  logic [3:0]   in_tag, out_tag;

  // NB = 8 and NB = 6 instances
  logic         v8, r8, inv8, ov8, ordy8;
  logic [255:0] d8, od8;
  logic [3:0]   t8, ot8;
  logic         v6, r6, inv6, ov6, ordy6;
  logic [191:0] d6, od6;
  logic [3:0]   t6, ot6;

  shift_rows_pipe #(.NB(4), .TAG_W(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
    .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (
    .clock(clock), .reset(reset), .in_valid(v8), .in_ready(r8), .in_inv(inv8),
    .in_data(d8), .in_tag(t8), .out_valid(ov8), .out_ready(ordy8),
    .out_data(od8), .out_tag(ot8)
  );

  shift_rows_pipe #(.NB(6), .TAG_W(4)) dut6 (
    .clock(clock), .reset(reset), .in_valid(v6), .in_ready(r6), .in_inv(inv6),
    .in_data(d6), .in_tag(t6), .out_valid(ov6), .out_ready(ordy6),
    .out_data(od6), .out_tag(ot6)
  );

  int checks = 0;
  int passed = 0;
  int nout   = 0;

  task automatic check_val(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Reference model: unpack into a row/column byte grid, rotate each row.
  function automatic logic [255:0] ref_shift(int nb, logic [255:0] d, logic inv);
    logic [7:0]   b [4][8];
    logic [255:0] o = '0;
    int w = 32 * nb;
    int off, src;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++) b[r][c] = d[w-1-8*(r*nb+c) -: 8];
    for (int r = 0; r < 4; r++) begin
      off = (nb == 8 && r > 1) ? r + 1 : r;
      for (int c = 0; c < nb; c++) begin
        src = inv ? (c + nb - off) % nb : (c + off) % nb;
        o[w-1-8*(r*nb+c) -: 8] = b[r][src];
      end
    end
    return o;
  endfunction

  typedef struct packed {
    logic [127:0] d;
    logic [3:0]   t;
  } item_t;
  item_t sb[$];

  // Scoreboard: outputs popped/compared, accepted inputs pushed, sampled mid-cycle.
  always @(negedge clock) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        nout++;
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL sb_underflow: got tag %h with nothing expected", out_tag);
        end else begin
          item_t it;
          it = sb.pop_front();
          check_val("sb_data", out_data, it.d);
          check_val("sb_tag", out_tag, it.t);
        end
      end
      if (in_valid && in_ready) sb.push_back({exp_data, in_tag});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Hold a block on the input until accepted (bounded); in_valid stays high on return.
  task automatic send(logic inv, logic [127:0] d, logic [3:0] t);
    in_valid = 1'b1;
    in_inv   = inv;
    in_data  = d;
    in_tag   = t;
    exp_data = ref_shift(4, {128'd0, d}, inv);
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (in_ready) break;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL send_timeout: in_ready got 0 want 1 for tag %h", t);
    end
    tick();
  endtask

  task automatic shot8(logic inv, logic [255:0] d, logic [255:0] e, string nm);
    v8 = 1'b1; inv8 = inv; d8 = d;
    @(negedge clock);
    check_val({nm, "_rdy"}, r8, 1);
    tick();
    v8 = 1'b0;
    check_val({nm, "_vld"}, ov8, 1);
    check_val(nm, od8, e);
  endtask

  task automatic shot6(logic inv, logic [255:0] d, logic [255:0] e, string nm);
    v6 = 1'b1; inv6 = inv; d6 = d[191:0];
    @(negedge clock);
    check_val({nm, "_rdy"}, r6, 1);
    tick();
    v6 = 1'b0;
    check_val({nm, "_vld"}, ov6, 1);
    check_val(nm, od6, e);
  endtask

  typedef struct {
    logic         inv;
    logic [127:0] din;
    logic [127:0] dexp;
    logic [3:0]   tag;
  } vec_t;

  localparam logic [127:0] T1In  = 128'h00010203_04050607_08090A0B_0C0D0E0F;
  localparam logic [127:0] T1Out = 128'h00010203_05060704_0A0B0809_0F0C0D0E;
  localparam logic [127:0] T2Out = 128'h00010203_07040506_0A0B0809_0D0E0F0C;
  localparam logic [255:0] T8Out =
    256'h00010203_04050607_090A0B0C_0D0E0F08_13141516_17101112_1C1D1E1F_18191A1B;
  localparam logic [191:0] T6Out =
    192'h00010203_0405_0708_090A0B06_0E0F1011_0C0D_1516_17121314;

  vec_t         vt [4];
  logic [127:0] blk [3];
  logic [255:0] seq8, seq6;
  int           n0;

  initial begin
    vt[0] = '{inv: 1'b0, din: T1In,  dexp: T1Out, tag: 4'h1};
    vt[1] = '{inv: 1'b1, din: T1In,  dexp: T2Out, tag: 4'h2};
    vt[2] = '{inv: 1'b1, din: T1Out, dexp: T1In,  tag: 4'h3};
    vt[3] = '{inv: 1'b0, din: T2Out, dexp: T1In,  tag: 4'h4};

    reset = 1'b1;
    in_valid = 1'b0; in_inv = 1'b0; in_data = '0; in_tag = '0; exp_data = '0;
    out_ready = 1'b0;
    v8 = 1'b0; inv8 = 1'b0; d8 = '0; t8 = '0; ordy8 = 1'b1;
    v6 = 1'b0; inv6 = 1'b0; d6 = '0; t6 = '0; ordy6 = 1'b1;

    // Reset state and in_ready rising one edge after release
    repeat (3) tick();
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_out_tag", out_tag, 0);
    reset = 1'b0;
    check_val("rel_in_ready_0", in_ready, 0);
    tick();
    check_val("rel_in_ready_1", in_ready, 1);
    check_val("rel_out_valid", out_valid, 0);

    // T1/T2: table vectors, one-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(vt[i].inv, vt[i].din, vt[i].tag);
      check_val("tbl_valid", out_valid, 1);
      check_val("tbl_data", out_data, vt[i].dexp);
      check_val("tbl_tag", out_tag, vt[i].tag);
    end
    in_valid = 1'b0;
    tick();

    // T3: NB = 8 and NB = 6 forward constants and round trips
    for (int i = 0; i < 32; i++) seq8[255-8*i -: 8] = i[7:0];
    seq6 = '0;
    for (int i = 0; i < 24; i++) seq6[191-8*i -: 8] = i[7:0];
    shot8(1'b0, seq8, T8Out, "nb8_fwd");
    shot8(1'b1, T8Out, seq8, "nb8_rtrip");
    shot6(1'b0, seq6, {64'd0, T6Out}, "nb6_fwd");
    shot6(1'b1, {64'd0, T6Out}, seq6, "nb6_rtrip");
    tick();

    // T4: backpressure, tags 1,2,3
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
    send(1'b0, blk[0], 4'h1);
    send(1'b1, blk[1], 4'h2);
    check_val("bp_full_ready", in_ready, 0);
    fork
      send(1'b0, blk[2], 4'h3);
      begin
        for (int k = 0; k < 3; k++) begin
          tick();
          check_val("bp_hold_valid", out_valid, 1);
          check_val("bp_hold_tag", out_tag, 1);
          check_val("bp_hold_data", out_data, ref_shift(4, {128'd0, blk[0]}, 1'b0));
          check_val("bp_hold_ready", in_ready, 0);
        end
        check_val("bp_sb_depth", sb.size(), 2);
        out_ready = 1'b1;
      end
    join
    in_valid = 1'b0;
    for (int k = 0; k < 20 && out_valid; k++) tick();
    check_val("bp_drained", out_valid, 0);
    check_val("bp_sb_empty", sb.size(), 0);

    // T5: streaming 16 blocks at one per clock, alternating direction
    n0 = nout;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_inv   = i[0];
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      in_tag   = i[3:0];
      exp_data = ref_shift(4, {128'd0, in_data}, in_inv);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check_val("stream_count", nout - n0, 16);
    check_val("stream_sb_empty", sb.size(), 0);

    // T6: reset while full
    out_ready = 1'b0;
    send(1'b0, T1In, 4'h5);
    send(1'b1, T1In, 4'h6);
    in_valid = 1'b0;
    check_val("t6_full_ready", in_ready, 0);
    #2 reset = 1'b1;
    #1;
    check_val("t6_rst_valid", out_valid, 0);
    check_val("t6_rst_ready", in_ready, 0);
    check_val("t6_rst_data", out_data, 0);
    check_val("t6_rst_tag", out_tag, 0);
    repeat (2) tick();
    reset = 1'b0;
    out_ready = 1'b1;
    check_val("t6_rel_ready_0", in_ready, 0);
    tick();
    check_val("t6_rel_ready_1", in_ready, 1);
    n0 = nout;
    repeat (3) tick();
    check_val("t6_no_stale", nout - n0, 0);
    send(1'b0, T1In, 4'h7);
    in_valid = 1'b0;
    check_val("t6_post_data", out_data, T1Out);
    check_val("t6_post_tag", out_tag, 7);
    tick();
    check_val("final_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
